// File: rtl/c_stream_ctrl_if.sv
// Beat and response handshake bundle for c_stream_ctrl.
// Carries i_abort only when C_STREAM_CTRL_ABORT_EN is defined.
interface c_stream_ctrl_if #(
  parameter int P_W         = 8,
  parameter int P_MAX_BEATS = 16
);
  localparam int LW = $clog2(P_W * P_MAX_BEATS) + 1;

  logic           i_valid;
  logic [P_W-1:0] i_data;
  logic           i_last;
  logic           o_ready;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic           o_rsp_is_unary;
  logic           o_rsp_all_term;
  logic           o_rsp_ovf;
  logic [LW-1:0]  o_rsp_len;
  logic           o_busy;
`ifdef C_STREAM_CTRL_ABORT_EN
  logic           i_abort;

  modport master (
    output i_valid, i_data, i_last, i_rsp_ready, i_abort,
    input  o_ready, o_rsp_valid, o_rsp_is_unary, o_rsp_all_term, o_rsp_ovf, o_rsp_len, o_busy
  );
  modport slave (
    input  i_valid, i_data, i_last, i_rsp_ready, i_abort,
    output o_ready, o_rsp_valid, o_rsp_is_unary, o_rsp_all_term, o_rsp_ovf, o_rsp_len, o_busy
  );
`else
  modport master (
    output i_valid, i_data, i_last, i_rsp_ready,
    input  o_ready, o_rsp_valid, o_rsp_is_unary, o_rsp_all_term, o_rsp_ovf, o_rsp_len, o_busy
  );
  modport slave (
    input  i_valid, i_data, i_last, i_rsp_ready,
    output o_ready, o_rsp_valid, o_rsp_is_unary, o_rsp_all_term, o_rsp_ovf, o_rsp_len, o_busy
  );
`endif
endinterface

// File: rtl/c_stream_ctrl.sv
// Streaming unary-code detector: accumulates beats of a vector and reports verdict,
// all-terminal flag, overflow and leading-run length. Optional abort: C_STREAM_CTRL_ABORT_EN.
module c_stream_ctrl #(
  parameter int P_W             = 8,
  parameter int P_MAX_BEATS     = 16,
  parameter int P_IS_COMPLIMENT = 0
) (
  input  logic           clk,
  input  logic           arst_n,
  c_stream_ctrl_if.slave bus
);
  localparam int LW = $clog2(P_W * P_MAX_BEATS) + 1;
  localparam int CW = $clog2(P_MAX_BEATS + 1);
  localparam logic LEAD = (P_IS_COMPLIMENT != 0) ? 1'b0 : 1'b1;
  localparam logic TERM = ~LEAD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_msb_q, prev_msb_d;
  logic          edge_q, edge_d;
  logic          bad_q, bad_d;
  logic          nonterm_q, nonterm_d;
  logic [LW-1:0] len_q, len_d;
  logic          rsp_unary_q, rsp_unary_d;
  logic          rsp_all_term_q, rsp_all_term_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic [LW-1:0] rsp_len_q, rsp_len_d;

  logic          accept;
  logic          edge_c, bad_c, nonterm_c, pb_c, ovf_c, unary_c;
  logic [LW-1:0] len_c;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prev_msb_d     = prev_msb_q;
    edge_d         = edge_q;
    bad_d          = bad_q;
    nonterm_d      = nonterm_q;
    len_d          = len_q;
    rsp_unary_d    = rsp_unary_q;
    rsp_all_term_d = rsp_all_term_q;
    rsp_ovf_d      = rsp_ovf_q;
    rsp_len_d      = rsp_len_q;

    accept    = bus.i_valid && (state_q != S_RESP);
    edge_c    = edge_q;
    bad_c     = bad_q;
    nonterm_c = nonterm_q;
    len_c     = len_q;
    pb_c      = prev_msb_q;
    ovf_c     = 1'b0;
    unary_c   = 1'b0;

    // bad_c folds "wrong lead value" and "second edge" into one non-admit flag
    for (int unsigned k = 0; k < P_W; k++) begin
      if (k == 0 && cnt_q == '0) begin
        if (bus.i_data[k] != LEAD) bad_c = 1'b1;
      end else if (bus.i_data[k] != pb_c) begin
        if (edge_c) begin
          bad_c = 1'b1;
        end else begin
          edge_c = 1'b1;
          len_c  = LW'(32'(cnt_q) * P_W + k);
        end
      end
      if (bus.i_data[k] != TERM) nonterm_c = 1'b1;
      pb_c = bus.i_data[k];
    end

    if (accept) begin
      if (bus.i_last || cnt_q == CW'(P_MAX_BEATS - 1)) begin
        ovf_c          = !bus.i_last;
        unary_c        = !ovf_c && !bad_c && edge_c && (pb_c == TERM);
        state_d        = S_RESP;
        rsp_unary_d    = unary_c;
        rsp_all_term_d = !nonterm_c;
        rsp_ovf_d      = ovf_c;
        rsp_len_d      = unary_c ? len_c : '0;
        cnt_d          = '0;
        prev_msb_d     = 1'b0;
        edge_d         = 1'b0;
        bad_d          = 1'b0;
        nonterm_d      = 1'b0;
        len_d          = '0;
      end else begin
        state_d    = S_ACCUM;
        cnt_d      = cnt_q + CW'(1);
        prev_msb_d = pb_c;
        edge_d     = edge_c;
        bad_d      = bad_c;
        nonterm_d  = nonterm_c;
        len_d      = len_c;
      end
    end else if (state_q == S_RESP && bus.i_rsp_ready) begin
      state_d        = S_IDLE;
      rsp_unary_d    = 1'b0;
      rsp_all_term_d = 1'b0;
      rsp_ovf_d      = 1'b0;
      rsp_len_d      = '0;
    end

`ifdef C_STREAM_CTRL_ABORT_EN
    if (bus.i_abort && state_q != S_IDLE) begin
      state_d        = S_IDLE;
      cnt_d          = '0;
      prev_msb_d     = 1'b0;
      edge_d         = 1'b0;
      bad_d          = 1'b0;
      nonterm_d      = 1'b0;
      len_d          = '0;
      rsp_unary_d    = 1'b0;
      rsp_all_term_d = 1'b0;
      rsp_ovf_d      = 1'b0;
      rsp_len_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      prev_msb_q     <= 1'b0;
      edge_q         <= 1'b0;
      bad_q          <= 1'b0;
      nonterm_q      <= 1'b0;
      len_q          <= '0;
      rsp_unary_q    <= 1'b0;
      rsp_all_term_q <= 1'b0;
      rsp_ovf_q      <= 1'b0;
      rsp_len_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_msb_q     <= prev_msb_d;
      edge_q         <= edge_d;
      bad_q          <= bad_d;
      nonterm_q      <= nonterm_d;
      len_q          <= len_d;
      rsp_unary_q    <= rsp_unary_d;
      rsp_all_term_q <= rsp_all_term_d;
      rsp_ovf_q      <= rsp_ovf_d;
      rsp_len_q      <= rsp_len_d;
    end
  end

  assign bus.o_ready        = (state_q != S_RESP);
  assign bus.o_rsp_valid    = (state_q == S_RESP);
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_rsp_is_unary = rsp_unary_q;
  assign bus.o_rsp_all_term = rsp_all_term_q;
  assign bus.o_rsp_ovf      = rsp_ovf_q;
  assign bus.o_rsp_len      = rsp_len_q;
endmodule

// File: tb/tb_c_stream_ctrl.sv
// Randomized bench for c_stream_ctrl: two instances (lead 1 and complemented) share
// one stimulus stream and are checked against a bit-vector reference model.
module tb_c_stream_ctrl;
  logic clk = 1'b0;
  logic arst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  c_stream_ctrl_if #(.P_W(8), .P_MAX_BEATS(4)) bus0 ();
  c_stream_ctrl_if #(.P_W(8), .P_MAX_BEATS(4)) bus1 ();

  assign bus1.i_valid     = bus0.i_valid;
  assign bus1.i_data      = bus0.i_data;
  assign bus1.i_last      = bus0.i_last;
  assign bus1.i_rsp_ready = bus0.i_rsp_ready;
`ifdef C_STREAM_CTRL_ABORT_EN
  assign bus1.i_abort     = bus0.i_abort;
`endif

  c_stream_ctrl #(.P_W(8), .P_MAX_BEATS(4), .P_IS_COMPLIMENT(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .bus(bus0));
  c_stream_ctrl #(.P_W(8), .P_MAX_BEATS(4), .P_IS_COMPLIMENT(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .bus(bus1));

  typedef struct {
    int unary;
    int all_term;
    int ovf;
    int len;
  } rsp_t;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector index i lives at v[i]; n beats of 8 bits each.
  function automatic rsp_t ref_rsp(input logic [31:0] v, input int n, input logic last,
                                   input int comp);
    rsp_t r;
    int   nbits = 8 * n;
    int   edges = 0;
    int   first = 0;
    int   lead  = comp ? 0 : 1;
    int   term  = 1 - lead;
    int   allt  = 1;
    for (int i = 0; i < nbits; i++) begin
      if (int'(v[i]) != term) allt = 0;
      if (i > 0 && v[i] != v[i-1]) begin
        if (edges == 0) first = i;
        edges++;
      end
    end
    r.ovf      = last ? 0 : 1;
    r.all_term = allt;
    r.unary    = (last && int'(v[0]) == lead && edges == 1 && int'(v[nbits-1]) == term) ? 1 : 0;
    r.len      = r.unary ? first : 0;
    return r;
  endfunction

  task automatic check_rsp(input string tag, input rsp_t e0, input rsp_t e1);
    check({tag, ".unary0"},  int'(bus0.o_rsp_is_unary), e0.unary);
    check({tag, ".allterm0"}, int'(bus0.o_rsp_all_term), e0.all_term);
    check({tag, ".ovf0"},    int'(bus0.o_rsp_ovf),      e0.ovf);
    check({tag, ".len0"},    int'(bus0.o_rsp_len),      e0.len);
    check({tag, ".unary1"},  int'(bus1.o_rsp_is_unary), e1.unary);
    check({tag, ".allterm1"}, int'(bus1.o_rsp_all_term), e1.all_term);
    check({tag, ".ovf1"},    int'(bus1.o_rsp_ovf),      e1.ovf);
    check({tag, ".len1"},    int'(bus1.o_rsp_len),      e1.len);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, int'(bus0.o_rsp_valid), 0);
    check({tag, ".busy"},  int'(bus0.o_busy),      0);
    check({tag, ".ready"}, int'(bus0.o_ready),     1);
    check({tag, ".busy1"}, int'(bus1.o_busy),      0);
  endtask

  // Sends n beats, checks the response, holds it for `hold` cycles, then drains.
  task automatic run_vec(input string tag, input logic [31:0] v, input int n,
                         input logic last, input int hold);
    rsp_t e0, e1;
    e0 = ref_rsp(v, n, last, 0);
    e1 = ref_rsp(v, n, last, 1);
    for (int b = 0; b < n; b++) begin
      bus0.i_valid = 1'b1;
      bus0.i_data  = v[8*b +: 8];
      bus0.i_last  = last && (b == n - 1);
      check({tag, ".rdy"}, int'(bus0.o_ready), 1);
      @(posedge clk); #1;
      if (b != n - 1) begin
        check({tag, ".mid_valid"}, int'(bus0.o_rsp_valid), 0);
        check({tag, ".mid_busy"},  int'(bus0.o_busy),      1);
      end
    end
    bus0.i_valid = 1'b0;
    bus0.i_last  = 1'b0;
    check({tag, ".rsp_valid"}, int'(bus0.o_rsp_valid), 1);
    check({tag, ".rsp_valid1"}, int'(bus1.o_rsp_valid), 1);
    check({tag, ".rsp_busy"},  int'(bus0.o_busy),      1);
    check({tag, ".rsp_ready"}, int'(bus0.o_ready),     0);
    check_rsp(tag, e0, e1);
    for (int h = 0; h < hold; h++) begin
      bus0.i_valid = 1'b1;
      bus0.i_data  = 8'($urandom);
      bus0.i_last  = 1'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold_ready"}, int'(bus0.o_ready),     0);
      check({tag, ".hold_valid"}, int'(bus0.o_rsp_valid), 1);
      check_rsp({tag, ".hold"}, e0, e1);
    end
    bus0.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.i_rsp_ready = 1'b0;
    bus0.i_valid     = 1'b0;
    bus0.i_last      = 1'b0;
    check_idle({tag, ".drain"});
  endtask

  initial begin
    logic [63:0] u;
    logic [31:0] v;
    int          n, len;
    logic        last;

    arst_n           = 1'b0;
    bus0.i_valid     = 1'b0;
    bus0.i_data      = '0;
    bus0.i_last      = 1'b0;
    bus0.i_rsp_ready = 1'b0;
`ifdef C_STREAM_CTRL_ABORT_EN
    bus0.i_abort     = 1'b0;
`endif
    #7;
    check("rst.valid", int'(bus0.o_rsp_valid), 0);
    check("rst.busy",  int'(bus0.o_busy), 0);
    check("rst.unary", int'(bus0.o_rsp_is_unary), 0);
    check("rst.len",   int'(bus0.o_rsp_len), 0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("rst.rel");

    run_vec("d0F",   32'h0000_000F, 1, 1'b1, 0);
    run_vec("dFF03", 32'h0000_03FF, 2, 1'b1, 1);
    run_vec("dFF00", 32'h0000_00FF, 2, 1'b1, 0);
    run_vec("d05",   32'h0000_0005, 1, 1'b1, 0);
    run_vec("d00",   32'h0000_0000, 1, 1'b1, 0);
    run_vec("dFF",   32'h0000_00FF, 1, 1'b1, 0);
    run_vec("dF0",   32'h0000_00F0, 1, 1'b1, 0);
    run_vec("ovf",   32'hFFFF_FFFF, 4, 1'b0, 5);
    run_vec("d0F3",  32'h000F_FFFF, 3, 1'b1, 2);

    // Reset with two of three beats accumulated
    for (int b = 0; b < 2; b++) begin
      bus0.i_valid = 1'b1;
      bus0.i_data  = 8'hFF;
      bus0.i_last  = 1'b0;
      @(posedge clk); #1;
    end
    bus0.i_valid = 1'b0;
    check("prerst.busy", int'(bus0.o_busy), 1);
    #2 arst_n = 1'b0;
    #1;
    check("midrst.busy",  int'(bus0.o_busy), 0);
    check("midrst.valid", int'(bus0.o_rsp_valid), 0);
    @(negedge clk) arst_n = 1'b1;
    run_vec("post_rst", 32'h0000_0001, 1, 1'b1, 0);

    // Reset while a response is pending
    bus0.i_valid = 1'b1;
    bus0.i_data  = 8'h0F;
    bus0.i_last  = 1'b1;
    @(posedge clk); #1;
    bus0.i_valid = 1'b0;
    bus0.i_last  = 1'b0;
    check("rsprst.pre", int'(bus0.o_rsp_is_unary), 1);
    #2 arst_n = 1'b0;
    #1;
    check("rsprst.valid", int'(bus0.o_rsp_valid), 0);
    check("rsprst.unary", int'(bus0.o_rsp_is_unary), 0);
    check("rsprst.len",   int'(bus0.o_rsp_len), 0);
    check("rsprst.ovf1",  int'(bus1.o_rsp_ovf), 0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("rsprst.rel");

    for (int t = 0; t < 60; t++) begin
      n    = int'($urandom_range(1, 4));
      last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        default: begin
          len = int'($urandom_range(0, 8 * n));
          u   = (64'd1 << len) - 64'd1;
          v   = u[31:0];
          if ($urandom_range(0, 1) == 1) v = ~v;
          if ($urandom_range(0, 4) == 0) v[$urandom_range(0, 8 * n - 1)] ^= 1'b1;
        end
      endcase
      run_vec("rnd", v, n, last, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c_stream_ctrl.md
C_STREAM_CTRL -- requirements
Module: c_stream_ctrl

Interface
REQ-001 SHALL have parameter P_W, default 8, meaning data bits per beat (>=2).
REQ-002 SHALL have parameter P_MAX_BEATS, default 16, meaning maximum number of beats per vector (>=1).
REQ-003 SHALL have parameter P_IS_COMPLIMENT, default 0, meaning 1 admits complemented unary code (leading 0s, terminal 1s).
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_valid in 1, i_data in P_W, i_last in 1, o_ready out 1: input beat handshake; i_data[0] is the lowest vector index of the beat.
REQ-007 SHALL have ports o_rsp_valid out 1, i_rsp_ready in 1: response handshake.
REQ-008 SHALL have ports o_rsp_is_unary out 1, o_rsp_all_term out 1, o_rsp_ovf out 1, o_rsp_len out $clog2(P_W*P_MAX_BEATS)+1: verdict, all-terminal flag, overflow flag, leading-run length.
REQ-009 SHALL have port o_busy out 1, high when the FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, RESP; reset state IDLE.
REQ-011 SHALL drive o_ready=1 in IDLE and ACCUM, 0 in RESP; a beat is accepted when i_valid & o_ready.
REQ-012 SHALL, on accept in IDLE or ACCUM, go to RESP if i_last or beat count reaches P_MAX_BEATS, else to ACCUM.
REQ-013 SHALL treat vector index 0 as the lead value: 1 (0 if P_IS_COMPLIMENT) required for admission.
REQ-014 SHALL count an edge wherever bit[k] != bit[k-1], k>=1, including across beat boundaries, via a registered copy of the previous beat's MSB.
REQ-015 SHALL register edge_seen, admit (lead value ok and no second edge), all_term (every bit equals the terminal value) and run length across beats.
REQ-016 SHALL set o_rsp_is_unary = admit & edge_seen & final bit equals terminal value; a 1-bit vector is never unary.
REQ-017 SHALL set o_rsp_len = index of the first edge when o_rsp_is_unary=1, else 0.
REQ-018 SHALL set o_rsp_ovf=1 when RESP was entered on beat-count limit without i_last; o_rsp_is_unary SHALL be 0 in that case.
REQ-019 SHALL assert o_rsp_valid in RESP exactly one cycle after the final beat is accepted; latency 1 cycle.
REQ-020 SHALL hold all o_rsp_* stable while o_rsp_valid & ~i_rsp_ready; on handshake, go to IDLE and clear accumulators.
REQ-021 SHALL ignore i_data, i_last and i_valid while in RESP; no beat is lost since o_ready=0.

Reset
REQ-022 SHALL, on arst_n low, immediately force IDLE, o_rsp_valid=0, o_busy=0, all o_rsp_* = 0, accumulators cleared; o_ready=1 after release.
REQ-023 SHALL discard any partially accumulated vector on reset mid-operation; no response is produced for it.

Configuration
REQ-024 SHALL, with macro C_STREAM_CTRL_ABORT_EN defined, add port i_abort in 1: when high in ACCUM or RESP, the FSM returns to IDLE next cycle, accumulators clear and no response handshake occurs; i_abort has priority over beat accept and i_rsp_ready.
REQ-025 SHALL, without C_STREAM_CTRL_ABORT_EN, omit i_abort; behaviour is exactly REQ-010..REQ-021.

Verification (P_W=8, P_MAX_BEATS=4, P_IS_COMPLIMENT=0 unless noted)
REQ-026 SHALL cover: one beat 0x0F with last -> next cycle o_rsp_valid=1, is_unary=1, len=4, all_term=0, ovf=0.
REQ-027 SHALL cover: beats 0xFF then 0x03 with last -> is_unary=1, len=10; beats 0xFF then 0x00 -> is_unary=1, len=8 (edge on beat boundary).
REQ-028 SHALL cover: 0x05 last -> is_unary=0 (multiple edges); 0x00 last -> is_unary=0, all_term=1; 0xFF last -> is_unary=0 (no edge); P_IS_COMPLIMENT=1 with 0xF0 -> is_unary=1, len=4.
REQ-029 SHALL cover: four beats 0xFF without i_last -> RESP entered, ovf=1, is_unary=0.
REQ-030 SHALL cover: i_rsp_ready held 0 for 5 cycles with i_valid=1 -> o_ready=0, response values unchanged, no beat accepted; i_rsp_ready=1 -> IDLE next cycle.
REQ-031 SHALL cover: arst_n pulsed low after 2 of 3 beats -> outputs reset asynchronously; subsequent 0x01 last -> is_unary=1, len=1, unaffected by prior beats.
